// File: rtl/reg_dump_reader.sv
// reg_dump_reader
//   Sequential read-side companion to the 8x16 register file. A start pulse
//   accepted in IDLE stalls the pipeline, walks register addresses
//   0..NUM_REGS-1 over a dedicated read port, and streams each
//   (address, value) pair out through a valid/ready handshake. A running
//   16-bit checksum of every dumped value is accumulated along the way.
//
// Ports
//   clk, rst      clock; asynchronous active-high reset
//   start         dump request, only sampled while idle
//   rf_read_addr  address presented to the register-file read port
//   rf_read_data  combinational read data for rf_read_addr
//   cpu_stall     pipeline hold, high for the whole dump
//   out_valid     dump word valid
//   out_ready     consumer ready
//   out_addr      register address of the current word
//   out_data      register value of the current word
//   out_last      current word is the last register
//   busy          dump in progress
//   done          one-cycle pulse when the dump completes
//   checksum      sum of all dumped values, carry discarded

module reg_dump_reader #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 3,
    parameter int NUM_REGS = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] rf_read_addr,
    input  logic [DATA_W-1:0] rf_read_data,
    output logic              cpu_stall,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_DONE
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] idx;

    // The read port always looks at the current index; the file answers
    // combinationally, so the value is ready to capture at the LOAD edge.
    assign rf_read_addr = idx;

    // The pipeline hold is exactly the busy window.
    assign cpu_stall = busy;

    // Dump sequencer. All outputs are registered here so the consumer sees
    // glitch-free values. The word registers are only written at the LOAD
    // edge, which keeps them stable through any amount of backpressure and
    // makes them immune to read-data changes while a word is waiting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            idx       <= '0;
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            checksum  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // The previous checksum stays visible until a new dump
                    // is actually accepted.
                    if (start) begin
                        state    <= ST_LOAD;
                        idx      <= '0;
                        checksum <= '0;
                        busy     <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    out_data  <= rf_read_data;
                    out_addr  <= idx;
                    out_last  <= (idx == LAST_IDX);
                    out_valid <= 1'b1;
                    state     <= ST_SEND;
                end
                ST_SEND: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        checksum  <= checksum + out_data;
                        if (idx == LAST_IDX) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= ST_LOAD;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_dump_reader.sv
// tb_reg_dump_reader
//   Directed bench for reg_dump_reader. A small register-file array feeds the
//   read port. A transaction-level model expects words at addresses 0,1,2,...
//   carrying the register contents, and a checksum equal to the plain sum of
//   those values; the compare process checks every accepted word, every
//   stalled cycle and every done pulse against it. Directed sequences pin
//   latencies and checksums with hand-computed literals.

module tb_reg_dump_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        out_ready = 1'b0;
    logic        glitch = 1'b0;
    logic [2:0]  rf_read_addr;
    logic [15:0] rf_read_data;
    logic        cpu_stall;
    logic        out_valid;
    logic [2:0]  out_addr;
    logic [15:0] out_data;
    logic        out_last;
    logic        busy;
    logic        done;
    logic [15:0] checksum;

    logic [15:0] rf [8];

    int checks = 0;
    int failures = 0;

    reg_dump_reader dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .rf_read_addr (rf_read_addr),
        .rf_read_data (rf_read_data),
        .cpu_stall    (cpu_stall),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_addr     (out_addr),
        .out_data     (out_data),
        .out_last     (out_last),
        .busy         (busy),
        .done         (done),
        .checksum     (checksum)
    );

    always #5 clk = ~clk;

    // Register file read port; glitch corrupts the data while a word waits.
    always_comb begin
        rf_read_data = rf[rf_read_addr] ^ (glitch ? 16'hAAAA : 16'h0000);
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    // Drive inputs for one clock edge, return 1 time unit after that edge.
    task automatic applyStimulus(input logic s, input logic r);
        start     = s;
        out_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        checkOutput({tag, "_out_valid"}, out_valid, 0);
        checkOutput({tag, "_out_addr"}, out_addr, 0);
        checkOutput({tag, "_out_data"}, out_data, 0);
        checkOutput({tag, "_out_last"}, out_last, 0);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_cpu_stall"}, cpu_stall, 0);
        checkOutput({tag, "_done"}, done, 0);
        checkOutput({tag, "_checksum"}, checksum, 0);
        checkOutput({tag, "_rf_read_addr"}, rf_read_addr, 0);
    endtask

    task automatic load_ramp();
        for (int k = 0; k < 8; k++) rf[k] = 16'(32'h1111 * k);
    endtask

    // Runs a dump already accepted at the previous edge. Edge i counts from
    // the accepting edge; out_ready is low (and read data corrupted) for
    // bp_len edges from bp_start; start is pulsed on edge start_at.
    task automatic run_dump(input int bp_start, input int bp_len, input int start_at,
                            output int done_at, output int stall_cnt);
        logic rdy;
        done_at   = -1;
        stall_cnt = busy ? 1 : 0;
        for (int i = 1; i <= 60 && done_at < 0; i++) begin
            rdy    = !(i >= bp_start && i < bp_start + bp_len);
            glitch = !rdy;
            applyStimulus(i == start_at, rdy);
            if (busy) stall_cnt++;
            if (done) done_at = i;
        end
        glitch = 1'b0;
        if (done_at < 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL dump_timeout actual=no_done expected=done");
        end
    endtask

    // Model state: next expected address, accepted-word count, running sum.
    int          exp_addr;
    int          word_count;
    logic [15:0] model_sum;
    logic        prev_waiting;
    logic [2:0]  prev_addr;
    logic [15:0] prev_data;
    logic        prev_last;

    always @(negedge clk or posedge rst) begin
        if (rst) begin
            exp_addr     = 0;
            word_count   = 0;
            model_sum    = 16'h0000;
            prev_waiting = 1'b0;
        end else begin
            checkOutput("stall_eq_busy", cpu_stall, busy);
            if (prev_waiting) begin
                checkOutput("hold_valid", out_valid, 1);
                checkOutput("hold_addr", out_addr, prev_addr);
                checkOutput("hold_data", out_data, prev_data);
                checkOutput("hold_last", out_last, prev_last);
            end
            if (out_valid && out_ready) begin
                checkOutput("word_addr", out_addr, exp_addr);
                checkOutput("word_data", out_data, rf[exp_addr % 8]);
                checkOutput("word_last", out_last, exp_addr == 7);
                model_sum  = model_sum + rf[exp_addr % 8];
                exp_addr   = exp_addr + 1;
                word_count = word_count + 1;
            end
            prev_waiting = out_valid && !out_ready;
            prev_addr    = out_addr;
            prev_data    = out_data;
            prev_last    = out_last;
            if (done) begin
                checkOutput("done_checksum", checksum, model_sum);
                checkOutput("done_words", word_count, 8);
                exp_addr   = 0;
                word_count = 0;
                model_sum  = 16'h0000;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  done_at;
        int  stall;
        logic found;

        load_ramp();
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("init");
        rst = 1'b0;
        applyStimulus(0, 1);
        checkOutput("idle_busy", busy, 0);

        // Full dump with the consumer always ready.
        $display("[TB] full dump");
        applyStimulus(1, 1);
        checkOutput("accept_busy", busy, 1);
        checkOutput("accept_checksum", checksum, 0);
        run_dump(0, 0, 0, done_at, stall);
        checkOutput("full_done_at", done_at, 16);
        checkOutput("full_stall", stall, 17);
        checkOutput("full_checksum", checksum, 16'hDDDC);
        applyStimulus(0, 1);
        checkOutput("full_busy_after", busy, 0);
        applyStimulus(0, 0);
        applyStimulus(0, 0);
        checkOutput("idle_checksum_hold", checksum, 16'hDDDC);

        // Backpressure: word 3 waits three extra cycles.
        $display("[TB] backpressure");
        applyStimulus(1, 1);
        run_dump(8, 3, 0, done_at, stall);
        checkOutput("bp_done_at", done_at, 19);
        checkOutput("bp_stall", stall, 20);
        checkOutput("bp_checksum", checksum, 16'hDDDC);
        applyStimulus(0, 1);

        // Checksum wrap.
        $display("[TB] overflow");
        for (int k = 1; k < 8; k++) rf[k] = 16'hFFFF;
        applyStimulus(1, 1);
        run_dump(0, 0, 0, done_at, stall);
        checkOutput("wrap_checksum", checksum, 16'hFFF9);
        applyStimulus(0, 1);
        load_ramp();

        // start during SEND and during DONE is ignored; next IDLE accepts.
        $display("[TB] start ignored while busy");
        applyStimulus(1, 1);
        run_dump(0, 0, 4, done_at, stall);
        checkOutput("ign_done_at", done_at, 16);
        applyStimulus(1, 1);
        checkOutput("start_in_done_busy", busy, 0);
        applyStimulus(1, 1);
        checkOutput("restart_busy", busy, 1);
        checkOutput("restart_checksum", checksum, 0);
        run_dump(0, 0, 0, done_at, stall);
        checkOutput("restart_done_at", done_at, 16);
        checkOutput("restart_checksum_final", checksum, 16'hDDDC);
        applyStimulus(0, 1);

        // Reset while word 5 is being offered.
        $display("[TB] reset mid-dump");
        applyStimulus(1, 1);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            applyStimulus(0, 1);
            if (out_valid && out_addr == 3'd5) found = 1'b1;
        end
        checkOutput("reached_word5", found, 1);
        #2 rst = 1'b1;
        #1;
        check_reset_values("mid");
        @(posedge clk);
        #1;
        checkOutput("mid_done_held_low", done, 0);
        rst = 1'b0;
        applyStimulus(0, 0);
        applyStimulus(1, 1);
        run_dump(0, 0, 0, done_at, stall);
        checkOutput("post_reset_done_at", done_at, 16);
        checkOutput("post_reset_checksum", checksum, 16'hDDDC);
        applyStimulus(0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
